// File: rtl/xor_word.sv
// ---------------------------------------------------------------------------
// xor_word
//   Shared bitwise XOR datapath. Purely combinational; the arbiter places the
//   winning requester's operands on a/b and registers y.
//
// Ports:
//   a  in   WIDTH  operand a
//   b  in   WIDTH  operand b
//   y  out  WIDTH  a ^ b
// ---------------------------------------------------------------------------
module xor_word #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_share_arb.sv
// ---------------------------------------------------------------------------
// xor_share_arb
//   Round-robin arbiter sharing one XOR datapath between NREQ requesters.
//   A request is accepted (gnt pulse) when the response register is empty or
//   is being drained in the same cycle. The XOR of the winner's operands is
//   registered with the winner index and returned over a valid/ready handshake.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst_n      in   1           asynchronous active-low reset
//   req        in   NREQ        per-requester request
//   a_flat     in   NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
//   b_flat     in   NREQ*WIDTH  operand b, same packing
//   gnt        out  NREQ        one-hot accept strobe (capture cycle only)
//   rsp_valid  out  1           response register holds a result
//   rsp_y      out  WIDTH       captured a ^ b
//   rsp_id     out  IDW         index of the requester that produced rsp_y
//   rsp_ready  in   1           consumer takes the response when high
//   txn_count  out  16          completed responses, wraps at 16 bits
// ---------------------------------------------------------------------------
module xor_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_flat,
    input  logic [NREQ*WIDTH-1:0] b_flat,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_y,
    output logic [IDW-1:0]        rsp_id,
    input  logic                  rsp_ready,
    output logic [15:0]           txn_count
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] y;
    } rsp_t;

    state_t           state, state_nx;
    rsp_t             rsp_q;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   ptr_nx;

    logic             can_accept;
    logic             capture;
    logic             rsp_done;

    logic [NREQ-1:0]  req_hi;      // requests at or above rr_ptr
    logic [IDW-1:0]   hi_idx;
    logic [IDW-1:0]   lo_idx;
    logic [IDW-1:0]   win_idx;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] y_sel;

    // -----------------------------------------------------------------------
    // Accept / complete conditions
    // -----------------------------------------------------------------------
    assign can_accept = (state == IDLE) || rsp_ready;
    assign capture    = can_accept && (|req);
    assign rsp_done   = (state == BUSY) && rsp_ready;

    // -----------------------------------------------------------------------
    // Round-robin search. Instead of a rotating index, split the requests into
    // those at or above rr_ptr and the rest: the lowest set bit of the upper
    // group wins, otherwise the lowest set bit overall (which then lies below
    // rr_ptr). This is the same order as scanning rr_ptr, rr_ptr+1, ... mod
    // NREQ, without any modular index arithmetic.
    // -----------------------------------------------------------------------
    always_comb begin
        req_hi = '0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_hi[i] = req[i] && (IDW'(i) >= rr_ptr);
        end
        // Descending scan so the lowest set index is the last one written.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_hi[i]) hi_idx = IDW'(i);
            if (req[i])    lo_idx = IDW'(i);
        end
        win_idx = (|req_hi) ? hi_idx : lo_idx;
    end

    // Pointer moves to the slot after the winner so it has lowest priority.
    always_comb begin
        if (win_idx == IDW'(NREQ - 1)) ptr_nx = '0;
        else                           ptr_nx = win_idx + 1'b1;
    end

    // gnt is gated with rst_n: in reset the FSM reads IDLE, which would
    // otherwise let a live req produce a strobe.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = capture && rst_n && (win_idx == IDW'(i));
        end
    end

    // -----------------------------------------------------------------------
    // Winner operand mux feeding the single shared XOR
    // -----------------------------------------------------------------------
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                a_sel = a_flat[i*WIDTH +: WIDTH];
                b_sel = b_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    xor_word #(
        .WIDTH (WIDTH)
    ) u_xor (
        .a (a_sel),
        .b (b_sel),
        .y (y_sel)
    );

    // -----------------------------------------------------------------------
    // FSM: BUSY means the response register is full
    // -----------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        if (capture)       state_nx = BUSY;   // new data, possibly replacing a drained one
        else if (rsp_done) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // -----------------------------------------------------------------------
    // Response register and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q  <= '0;
            rr_ptr <= '0;
        end else if (capture) begin
            rsp_q.id <= win_idx;
            rsp_q.y  <= y_sel;
            rr_ptr   <= ptr_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        txn_count <= '0;
        else if (rsp_done) txn_count <= txn_count + 16'd1;
    end

    assign rsp_valid = (state == BUSY);
    assign rsp_y     = rsp_q.y;
    assign rsp_id    = rsp_q.id;

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed bench for xor_share_arb. Stimulus pushes the expected {id, y} of
// every response it causes; a monitor pops and compares on each handshake.
module tb_xor_share_arb;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_flat;
    logic [NREQ*WIDTH-1:0] b_flat;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [WIDTH-1:0]      rsp_y;
    logic [IDW-1:0]        rsp_id;
    logic                  rsp_ready;
    logic [15:0]           txn_count;

    xor_share_arb #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [IDW+WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0]     ytab[NREQ];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_flat[i*WIDTH +: WIDTH] = a;
        b_flat[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic push(input int id, input logic [WIDTH-1:0] y);
        exp_q.push_back({IDW'(id), y});
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one comparison per completed handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {22'd0, rsp_id, rsp_y}, 32'hFFFF_FFFF);
            end else begin
                logic [IDW+WIDTH-1:0] e;
                e = exp_q.pop_front();
                chk("rsp_id_y", {22'd0, rsp_id, rsp_y}, {22'd0, e});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Operand table: 0:01^10=11  1:23^45=66  2:F0^0F=FF  3:AA^AA=00
        ytab[0] = 8'h11; ytab[1] = 8'h66; ytab[2] = 8'hFF; ytab[3] = 8'h00;
        a_flat = '0; b_flat = '0;
        set_op(0, 8'h01, 8'h10);
        set_op(1, 8'h23, 8'h45);
        set_op(2, 8'hF0, 8'h3C);   // single-request vector: F0^3C = CC
        set_op(3, 8'hAA, 8'hAA);
        rst_n = 1'b0; req = 4'b1111; rsp_ready = 1'b0;

        // ---- reset state, gnt held low despite requests ----
        @(negedge clk);
        chk("rst_gnt",       gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_y",     rsp_y, 0);
        chk("rst_rsp_id",    rsp_id, 0);
        chk("rst_txn",       txn_count, 0);
        step();
        req = '0; rst_n = 1'b1;
        step();

        // ---- single request on requester 2 ----
        rsp_ready = 1'b1; req = 4'b0100; push(2, 8'hCC);
        @(negedge clk); chk("single_gnt", gnt, 4'b0100);
        step(); req = '0;
        @(negedge clk); chk("single_valid", rsp_valid, 1); chk("single_gnt_off", gnt, 0);
        step();
        @(negedge clk); chk("single_txn", txn_count, 1); chk("single_idle", rsp_valid, 0);

        // ---- pointer wrap: rr_ptr=3, req=1001 -> 3 then 0 ----
        step();
        set_op(3, 8'h11, 8'h22); set_op(0, 8'h0F, 8'hFF);
        req = 4'b1001; push(3, 8'h33); push(0, 8'hF0);
        @(negedge clk); chk("wrap_gnt3", gnt, 4'b1000);
        step(); req = 4'b0001;
        @(negedge clk); chk("wrap_gnt0", gnt, 4'b0001);
        step(); req = '0;
        step();
        @(negedge clk); chk("wrap_txn", txn_count, 3);
        set_op(3, 8'hAA, 8'hAA); set_op(0, 8'h01, 8'h10); set_op(2, 8'hF0, 8'h0F);

        // ---- stall: rr_ptr=1; load requester 0, then hold ready low 5 cycles ----
        step();
        rsp_ready = 1'b0; req = 4'b0001; push(0, 8'h11);
        @(negedge clk); chk("stall_first_gnt", gnt, 4'b0001);
        step(); req = 4'b0011;
        repeat (5) begin
            @(negedge clk);
            chk("stall_gnt",   gnt, 0);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_y",     rsp_y, 8'h11);
            chk("stall_id",    rsp_id, 0);
            step();
        end
        rsp_ready = 1'b1; push(1, 8'h66);
        @(negedge clk); chk("stall_release_gnt", gnt, 4'b0010);
        step(); req = 4'b0001; push(0, 8'h11);
        @(negedge clk); chk("stall_next_gnt", gnt, 4'b0001);
        step(); req = '0;
        step();
        @(negedge clk); chk("stall_txn", txn_count, 6);

        // ---- reset while BUSY holding 5A ----
        step();
        rsp_ready = 1'b0; set_op(1, 8'h5A, 8'h00); req = 4'b0010;
        @(negedge clk); chk("pre_rst_gnt", gnt, 4'b0010);
        step(); req = '0;
        @(negedge clk); chk("pre_rst_y", rsp_y, 8'h5A); chk("pre_rst_valid", rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", rsp_valid, 0);
        chk("async_rst_y",     rsp_y, 0);
        chk("async_rst_id",    rsp_id, 0);
        chk("async_rst_txn",   txn_count, 0);
        step();
        rst_n = 1'b1; set_op(1, 8'h23, 8'h45);

        // ---- all request held: order 0,1,2,3,0,1,2,3 from rr_ptr=0 ----
        rsp_ready = 1'b1; req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            push(k % NREQ, ytab[k % NREQ]);
            @(negedge clk); chk("all_gnt", gnt, 32'd1 << (k % NREQ));
            step();
        end
        req = '0;
        step(); step();
        @(negedge clk); chk("all_txn", txn_count, 8);

        // ---- counter wrap: 65528 more back-to-back -> 65536 total -> 0 ----
        step();
        req = 4'b0001;
        for (int k = 0; k < 65528; k++) begin
            push(0, 8'h11);
            step();
        end
        req = '0;
        step(); step();
        @(negedge clk);
        chk("txn_wrap", txn_count, 0);
        chk("end_idle", rsp_valid, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xor_share_arb.md
Name: xor_share_arb

Overview:
Round-robin controller that shares one WIDTH-bit bitwise XOR datapath between NREQ requesters. Each requester presents two operands with a request. The block grants one requester at a time and captures the XOR result into a response register, returned with the requester index over a valid/ready handshake. It sits between multiple client blocks and a single shared XOR unit.

Parameters:
NREQ, 4, number of requesters (≥1)
WIDTH, 8, operand/result width in bits
IDW, $clog2(NREQ) (min 1), width of requester index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, bit i = requester i
a_flat  input  NREQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
b_flat  input  NREQ*WIDTH  operand b, same packing
gnt  output  NREQ  one-hot accept strobe, combinational, high only in capture cycle
rsp_valid  output  1  response register holds a result
rsp_y  output  WIDTH  captured a^b of granted requester
rsp_id  output  IDW  index of granted requester
rsp_ready  input  1  consumer accepts response when high with rsp_valid
txn_count  output  16  completed responses, wraps 0xFFFF->0

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, txn_count=0, rr_ptr=0, state=IDLE. gnt=0 while rst_n=0.
- States:
  - IDLE: rsp_valid=0.
  - BUSY: rsp_valid=1.
- can_accept = (state==IDLE) | (state==BUSY & rsp_ready).
- Capture cycle: can_accept & |req.
  - Winner = first set req bit searching rr_ptr, rr_ptr+1, … modulo NREQ.
  - gnt[winner]=1, all other gnt bits 0.
  - On that clock edge: rsp_y <= a[winner]^b[winner]; rsp_id <= winner; rr_ptr <= (winner+1) mod NREQ; state <= BUSY.
- Latency: result is visible on rsp_y/rsp_valid the cycle after gnt.
- Response handshake: rsp_valid & rsp_ready completes the response and increments txn_count by 1.
  - If a capture happens in the same cycle, state stays BUSY with new data.
  - Otherwise state goes to IDLE.
  - Throughput is 1 result/cycle when rsp_ready is held high.
- Stall: BUSY & !rsp_ready holds rsp_y, rsp_id and rsp_valid stable. gnt=0. rr_ptr is unchanged.
- Requester protocol: hold req, a and b stable until gnt is seen; deassert req or issue a new request the following cycle. The block does not support withdrawing req before gnt.
- Fairness: a requester holding req is granted within NREQ captures.
- NREQ=1: rr_ptr is constant 0 and rsp_id is 0.
- Reset mid-BUSY: the pending response is discarded and all state returns to reset values immediately, with no clock needed.
- No arithmetic except the XOR, the modulo-NREQ pointer increment, and the 16-bit wrap counter.

Decomposition:
- No shared package is needed. IDW is computed locally.
- One sub-module, xor_word: parameter WIDTH, combinational y = a ^ b. It is instantiated once, fed by the winner's operand mux.
- Round-robin priority search stays inline.

Test Plan:
- Reset: assert rst_n=0 mid-BUSY holding rsp_y=8'h5A -> rsp_valid=0, rsp_y=0, txn_count=0 immediately; first grant after release goes to the lowest requesting index.
- Single request: req=4'b0100, a2=8'hF0, b2=8'h3C, rsp_ready=1 -> gnt=4'b0100 for 1 cycle; next cycle rsp_valid=1, rsp_y=8'hCC, rsp_id=2; txn_count=1 after the handshake.
- All request: req=4'b1111 held (each drops after its gnt, re-requests next cycle), rsp_ready=1 -> grant order 0,1,2,3,0,… with one gnt per cycle; rsp_y matches each a^b.
- Stall: rsp_ready=0 for 5 cycles with req=4'b0011 pending -> gnt=0 and response stable throughout; on rsp_ready=1, the next gnt is issued in the same cycle as the handshake.
- Pointer wrap: rr_ptr=3 after granting 2, req=4'b1001 -> gnt to 3, then 0.
- Counter wrap: 65536 back-to-back transactions -> txn_count returns to 0.
